// File: rtl/conv_host_pkg.sv
// Shared types and default widths for the convolution HLS host block.
package conv_host_pkg;

   typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

   localparam int CH_DW          = 32;
   localparam int CH_IMG_AW      = 6;
   localparam int CH_KER_AW      = 2;
   localparam int CH_OUT_AW      = 6;
   localparam int CH_TIMEOUT_CYC = 4096;

   localparam logic LD_SEL_IMG = 1'b0;
   localparam logic LD_SEL_KER = 1'b1;

endpackage

// File: rtl/conv_host_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Read-first: a read and write to the same address in one cycle return the old word.
module conv_host_sdp_ram
   import conv_host_pkg::*;
#(
   parameter int DW = CH_DW,
   parameter int AW = CH_IMG_AW
)(
   input  logic          i_clk,
   input  logic          i_srst,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic          i_re,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   logic [DW-1:0] r_mem [2**AW];
   logic [DW-1:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Only the output register is reset; array contents survive reset.
   always_ff @(posedge i_clk) begin
      if (i_srst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/convolution_hls_host.sv
// Host side of the HLS convolution core: ap_ctrl_hs sequencing plus ap_memory responders.
// Define CONV_HOST_TIMEOUT_EN to enable the TIMEOUT_CYC watchdog (err output).
module convolution_hls_host
   import conv_host_pkg::*;
#(
   parameter int DW          = CH_DW,
   parameter int IMG_AW      = CH_IMG_AW,
   parameter int KER_AW      = CH_KER_AW,
   parameter int OUT_AW      = CH_OUT_AW,
   parameter int TIMEOUT_CYC = CH_TIMEOUT_CYC
)(
   input  logic              ap_clk,
   input  logic              ap_rst,
   input  logic              run,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [31:0]       run_cycles,
   output logic [OUT_AW:0]   wr_count,
   input  logic              ld_we,
   input  logic              ld_sel,
   input  logic [IMG_AW-1:0] ld_addr,
   input  logic [DW-1:0]     ld_data,
   input  logic [OUT_AW-1:0] rd_addr,
   output logic [DW-1:0]     rd_data,
   output logic              ap_start,
   input  logic              ap_done,
   input  logic              ap_idle,
   input  logic              ap_ready,
   input  logic              img_ce0,
   input  logic [IMG_AW-1:0] img_address0,
   output logic [DW-1:0]     img_q0,
   input  logic              kernel_ce0,
   input  logic [KER_AW-1:0] kernel_address0,
   output logic [DW-1:0]     kernel_q0,
   input  logic              output_r_ce0,
   input  logic              output_r_we0,
   input  logic [OUT_AW-1:0] output_r_address0,
   input  logic [DW-1:0]     output_r_d0
);

   localparam logic [OUT_AW:0] WR_MAX = {1'b1, {OUT_AW{1'b0}}};
   localparam logic [OUT_AW:0] WR_ONE = {{OUT_AW{1'b0}}, 1'b1};

   state_t            r_state;
   logic              r_ap_start;
   logic              r_busy;
   logic              r_done;
   logic              r_err;
   logic [31:0]       r_cyc_cnt;
   logic [31:0]       r_run_cycles;
   logic [OUT_AW:0]   r_wr_cnt;
   logic [OUT_AW:0]   r_wr_count;

   logic              w_core_wr;
   logic              w_ld_ok;
   logic              w_img_we;
   logic              w_ker_we;
   logic              w_timeout;
   logic              w_done_ok;
   logic [31:0]       w_cyc_next;
   logic [OUT_AW:0]   w_wr_next;
   logic              w_unused;

   assign w_core_wr  = output_r_ce0 & output_r_we0;
   assign w_ld_ok    = ld_we & ~r_busy;
   assign w_img_we   = w_ld_ok & (ld_sel == LD_SEL_IMG);
   assign w_ker_we   = w_ld_ok & (ld_sel == LD_SEL_KER);
   assign w_cyc_next = r_cyc_cnt + 32'd1;
   assign w_wr_next  = (w_core_wr && (r_wr_cnt != WR_MAX)) ? r_wr_cnt + WR_ONE : r_wr_cnt;
   // A done in START only counts together with ready (handshake completed in one cycle).
   assign w_done_ok  = ap_done && ((r_state == WAIT) || ap_ready);

`ifdef CONV_HOST_TIMEOUT_EN
   assign w_timeout = (w_cyc_next >= 32'(TIMEOUT_CYC));
`else
   assign w_timeout = 1'b0;
`endif

   // ap_idle is observed by the integrator only; nothing here depends on it.
   assign w_unused = ^{ap_idle, (TIMEOUT_CYC != 0)};

   always_ff @(posedge ap_clk) begin
      if (ap_rst) begin
         r_state      <= IDLE;
         r_ap_start   <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_err        <= 1'b0;
         r_cyc_cnt    <= '0;
         r_wr_cnt     <= '0;
         r_run_cycles <= '0;
         r_wr_count   <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (run) begin
                  r_state    <= START;
                  r_ap_start <= 1'b1;
                  r_busy     <= 1'b1;
                  r_err      <= 1'b0;
                  r_cyc_cnt  <= '0;
                  r_wr_cnt   <= '0;
               end
            end
            START, WAIT: begin
               r_cyc_cnt <= w_cyc_next;
               r_wr_cnt  <= w_wr_next;
               if (w_done_ok || w_timeout) begin
                  r_state      <= DONE;
                  r_ap_start   <= 1'b0;
                  r_busy       <= 1'b0;
                  r_done       <= 1'b1;
                  r_err        <= ~w_done_ok;
                  r_run_cycles <= w_cyc_next;
                  r_wr_count   <= w_wr_next;
               end else if ((r_state == START) && ap_ready) begin
                  r_state    <= WAIT;
                  r_ap_start <= 1'b0;
               end
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign ap_start   = r_ap_start;
   assign busy       = r_busy;
   assign done       = r_done;
   assign err        = r_err;
   assign run_cycles = r_run_cycles;
   assign wr_count   = r_wr_count;

   conv_host_sdp_ram #(.DW(DW), .AW(IMG_AW)) u_img_ram (
      .i_clk   (ap_clk),
      .i_srst  (ap_rst),
      .i_we    (w_img_we),
      .i_waddr (ld_addr),
      .i_wdata (ld_data),
      .i_re    (img_ce0),
      .i_raddr (img_address0),
      .o_rdata (img_q0)
   );

   conv_host_sdp_ram #(.DW(DW), .AW(KER_AW)) u_ker_ram (
      .i_clk   (ap_clk),
      .i_srst  (ap_rst),
      .i_we    (w_ker_we),
      .i_waddr (ld_addr[KER_AW-1:0]),
      .i_wdata (ld_data),
      .i_re    (kernel_ce0),
      .i_raddr (kernel_address0),
      .o_rdata (kernel_q0)
   );

   conv_host_sdp_ram #(.DW(DW), .AW(OUT_AW)) u_out_ram (
      .i_clk   (ap_clk),
      .i_srst  (ap_rst),
      .i_we    (w_core_wr),
      .i_waddr (output_r_address0),
      .i_wdata (output_r_d0),
      .i_re    (1'b1),
      .i_raddr (rd_addr),
      .o_rdata (rd_data)
   );

endmodule

// File: tb/tb_convolution_hls_host.sv
// Scoreboard bench for convolution_hls_host; the bench plays the HLS core.
// Build with CONV_HOST_TIMEOUT_EN to also exercise the watchdog (TIMEOUT_CYC=16).
module tb_convolution_hls_host;

`ifdef CONV_HOST_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 4096;
`endif

   logic        ap_clk = 1'b0;
   logic        ap_rst = 1'b1;
   logic        run = 1'b0;
   logic        busy, done, err;
   logic [31:0] run_cycles;
   logic [6:0]  wr_count;
   logic        ld_we = 1'b0, ld_sel = 1'b0;
   logic [5:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic [5:0]  rd_addr = '0;
   logic [31:0] rd_data;
   logic        ap_start;
   logic        ap_done = 1'b0, ap_idle = 1'b1, ap_ready = 1'b0;
   logic        img_ce0 = 1'b0;
   logic [5:0]  img_address0 = '0;
   logic [31:0] img_q0;
   logic        kernel_ce0 = 1'b0;
   logic [1:0]  kernel_address0 = '0;
   logic [31:0] kernel_q0;
   logic        output_r_ce0 = 1'b0, output_r_we0 = 1'b0;
   logic [5:0]  output_r_address0 = '0;
   logic [31:0] output_r_d0 = '0;

   always #5 ap_clk = ~ap_clk;

   convolution_hls_host #(.TIMEOUT_CYC(TMO)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .run(run), .busy(busy), .done(done), .err(err),
      .run_cycles(run_cycles), .wr_count(wr_count),
      .ld_we(ld_we), .ld_sel(ld_sel), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle), .ap_ready(ap_ready),
      .img_ce0(img_ce0), .img_address0(img_address0), .img_q0(img_q0),
      .kernel_ce0(kernel_ce0), .kernel_address0(kernel_address0), .kernel_q0(kernel_q0),
      .output_r_ce0(output_r_ce0), .output_r_we0(output_r_we0),
      .output_r_address0(output_r_address0), .output_r_d0(output_r_d0)
   );

   typedef struct {int cyc; int wr; bit er;} done_t;

   done_t       q_done[$];
   logic [31:0] q_img[$], q_ker[$], q_rd[$];
   logic [31:0] img_m [64];
   logic [31:0] ker_m [4];
   logic [31:0] out_m [64];
   int          n_vec = 0, n_err = 0;
   logic        rd_chk = 1'b0;
   logic        p_img = 1'b0, p_ker = 1'b0, p_rd = 1'b0;
   done_t       d_mon;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Reference: output word at a is a 4-tap 1-D convolution over the img model.
   function automatic logic [31:0] conv_at(int a);
      logic [31:0] s = '0;
      for (int k = 0; k < 4; k++) s += img_m[(a + k) % 64] * ker_m[k];
      return s;
   endfunction

   // Monitor: reads issued at a posedge are compared at the following negedge.
   always @(posedge ap_clk) begin
      p_img <= img_ce0 && !ap_rst;
      p_ker <= kernel_ce0 && !ap_rst;
      p_rd  <= rd_chk && !ap_rst;
   end

   always @(negedge ap_clk) begin
      if (p_img) begin
         if (q_img.size() == 0) chk("img_q0_unexpected", q_img.size(), 1);
         else chk("img_q0", img_q0, q_img.pop_front());
      end
      if (p_ker) begin
         if (q_ker.size() == 0) chk("kernel_q0_unexpected", q_ker.size(), 1);
         else chk("kernel_q0", kernel_q0, q_ker.pop_front());
      end
      if (p_rd) begin
         if (q_rd.size() == 0) chk("rd_data_unexpected", q_rd.size(), 1);
         else chk("rd_data", rd_data, q_rd.pop_front());
      end
      if (done) begin
         if (q_done.size() == 0) chk("done_spurious", done, 0);
         else begin
            d_mon = q_done.pop_front();
            chk("run_cycles", run_cycles, d_mon.cyc);
            chk("wr_count", wr_count, d_mon.wr);
            chk("err", err, d_mon.er);
         end
      end
   end

   task automatic preload(bit sel, int addr, logic [31:0] data);
      ld_we = 1'b1; ld_sel = sel; ld_addr = 6'(addr); ld_data = data;
      tick();
      ld_we = 1'b0;
      if (sel) ker_m[addr % 4] = data;
      else img_m[addr % 64] = data;
   endtask

   task automatic readback(int a);
      rd_addr = 6'(a); rd_chk = 1'b1; q_rd.push_back(out_m[a]);
      tick();
      rd_chk = 1'b0;
   endtask

   // One accelerator run as seen from the core side; c is the cycle index from ap_start rise.
   task automatic do_run(int ready_at, int n_wr, bit dwr, bit no_done, bit poke, bit rnd);
      int          c;
      int          a;
      done_t       d;
      run = 1'b1; ap_idle = 1'b0;
      tick();
      run = 1'b0;
      c = 1;
      chk("ap_start_rise", ap_start, 1);
      chk("busy_rise", busy, 1);
      chk("err_clear", err, 0);
      while (c < ready_at) begin tick(); c++; end
      ap_ready = 1'b1; ap_done = dwr;
      if (dwr) begin d = '{c, 0, 1'b0}; q_done.push_back(d); end
      tick(); c++;
      ap_ready = 1'b0; ap_done = 1'b0;
      if (!dwr && !no_done) begin
         chk("ap_start_wait", ap_start, 0);
         for (int i = 0; i < n_wr; i++) begin
            a = rnd ? int'($urandom_range(0, 63)) : i % 64;
            img_ce0 = 1'b1; img_address0 = 6'(i % 64); q_img.push_back(img_m[i % 64]);
            kernel_ce0 = 1'b1; kernel_address0 = 2'(i % 4); q_ker.push_back(ker_m[i % 4]);
            rd_addr = 6'(a); rd_chk = 1'b1; q_rd.push_back(out_m[a]);
            output_r_ce0 = 1'b1; output_r_we0 = 1'b1;
            output_r_address0 = 6'(a); output_r_d0 = conv_at(a); out_m[a] = conv_at(a);
            if (poke && i == 1) begin
               run = 1'b1; ld_we = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = ~img_m[0];
            end
            tick(); c++;
            run = 1'b0; ld_we = 1'b0;
         end
         img_ce0 = 1'b0; kernel_ce0 = 1'b0; rd_chk = 1'b0;
         // ce0 without we0 must neither store nor count
         output_r_we0 = 1'b0; output_r_address0 = 6'($urandom_range(0, 63)); output_r_d0 = $urandom;
         tick(); c++;
         output_r_ce0 = 1'b0;
         ap_done = 1'b1;
         d = '{c, (n_wr > 64) ? 64 : n_wr, 1'b0};
         q_done.push_back(d);
         tick();
         ap_done = 1'b0;
      end else if (no_done) begin
         d = '{TMO, 0, 1'b1};
         q_done.push_back(d);
         while (c <= TMO) begin tick(); c++; end
      end
      // DONE cycle
      chk("ap_start_done", ap_start, 0);
      chk("busy_done", busy, 0);
      run = poke;
      tick();
      run = 1'b0; ap_idle = 1'b1;
      chk("done_single", done, 0);
      chk("busy_idle", busy, 0);
      tick();
      chk("busy_after", busy, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 64; i++) begin img_m[i] = 'x; out_m[i] = 'x; end
      for (int i = 0; i < 4; i++) ker_m[i] = 'x;

      // Reset state
      ap_rst = 1'b1;
      repeat (3) tick();
      chk("rst_rd_data", rd_data, 0);
      chk("rst_img_q0", img_q0, 0);
      chk("rst_kernel_q0", kernel_q0, 0);
      chk("rst_err", err, 0);
      chk("rst_run_cycles", run_cycles, 0);
      chk("rst_wr_count", wr_count, 0);
      ap_rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_ap_start", ap_start, 0);
         chk("idle_busy", busy, 0);
         chk("idle_done", done, 0);
      end

      // img[i]=i, kernel={1,0,0,0}; kernel loaded through addresses with high bits set
      for (int i = 0; i < 64; i++) preload(1'b0, i, 32'(i));
      preload(1'b1, 40, 32'd1);
      for (int k = 1; k < 4; k++) preload(1'b1, 40 + k, 32'd0);
      do_run(3, 64, 1'b0, 1'b0, 1'b0, 1'b0);
      readback(5);
      readback(0);
      readback(63);

      // ready and done together in START, at several latencies
      do_run(1, 0, 1'b1, 1'b0, 1'b0, 1'b0);
      do_run(4, 0, 1'b1, 1'b0, 1'b0, 1'b0);

      // run and preload while busy are ignored
      do_run(2, 6, 1'b0, 1'b0, 1'b1, 1'b1);
      img_ce0 = 1'b1; img_address0 = '0; q_img.push_back(img_m[0]);
      tick();
      img_ce0 = 1'b0;

      // reset in the middle of WAIT
      run = 1'b1; ap_idle = 1'b0; tick(); run = 1'b0;
      tick();
      ap_ready = 1'b1; tick(); ap_ready = 1'b0;
      tick();
      chk("busy_wait", busy, 1);
      ap_rst = 1'b1; tick(); ap_rst = 1'b0; ap_idle = 1'b1;
      chk("rst_mid_ap_start", ap_start, 0);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_done", done, 0);
      for (int k = 0; k < 4; k++) begin
         img_ce0 = 1'b1; img_address0 = 6'(k * 7); q_img.push_back(img_m[k * 7]);
         tick();
      end
      img_ce0 = 1'b0;
      readback(5);

`ifdef CONV_HOST_TIMEOUT_EN
      do_run(3, 0, 1'b0, 1'b1, 1'b0, 1'b0);
      do_run(2, 3, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

      // write-counter saturation
      do_run(2, 70, 1'b0, 1'b0, 1'b0, 1'b1);

      // randomized runs
      for (int r = 0; r < 6; r++) begin
         int nw;
         for (int j = 0; j < 4; j++) preload(1'b0, int'($urandom_range(0, 63)), $urandom);
         preload(1'b1, int'($urandom_range(0, 63)), $urandom_range(0, 15));
         nw = int'($urandom_range(0, 40));
         do_run(int'($urandom_range(1, 5)), nw, (nw == 0) && ($urandom_range(0, 1) == 1),
                1'b0, 1'b0, 1'b1);
      end
      for (int j = 0; j < 8; j++) readback(int'($urandom_range(0, 63)));

      repeat (3) tick();
      chk("q_done_drained", q_done.size(), 0);
      chk("q_img_drained", q_img.size(), 0);
      chk("q_ker_drained", q_ker.size(), 0);
      chk("q_rd_drained", q_rd.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
